// File: rtl/vram_pkg.sv
// Shared types, defaults and helpers for the banked video RAM.
package vram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_BANKS  = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vram_banked_if.sv
// Request/response bus of the banked video RAM; master issues requests, slave serves them.
interface vram_banked_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wrdata;
    logic [DATA_W/8-1:0] bus_wrbytesel;
    logic                bus_write;
    logic                bus_valid;
    logic                bus_ready;
    logic [DATA_W-1:0]   bus_rddata;
    logic                bus_rdvalid;

    modport master (
        output bus_addr, bus_wrdata, bus_wrbytesel, bus_write, bus_valid,
        input  bus_ready, bus_rddata, bus_rdvalid
    );

    modport slave (
        input  bus_addr, bus_wrdata, bus_wrbytesel, bus_write, bus_valid,
        output bus_ready, bus_rddata, bus_rdvalid
    );
endinterface

// File: rtl/vram_bank.sv
// Single-port synchronous RAM bank with byte write enables and a registered read port.
// Read data lands one cycle after the request and holds until the next read.
module vram_bank #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [DATA_W-1:0]   wdat_i,
    output logic [DATA_W-1:0]   rdat_o
);
    logic [DATA_W-1:0] mem_q [0:(1<<IDX_W)-1];
    logic [DATA_W-1:0] rdat_q;

    // Storage is deliberately not reset; only the clear engine initialises it.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdat_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdat_q <= '0;
        end else if (en_i && !we_i) begin
            rdat_q <= mem_q[idx_i];
        end
    end

    assign rdat_o = rdat_q;
endmodule

// File: rtl/vram_banked.sv
// Banked video RAM with a full-memory clear engine that writes all banks in parallel.
// Reads return one cycle after acceptance; requests are stalled while clearing.
module vram_banked
    import vram_pkg::*;
#(
    parameter int                  DATA_W         = DEF_DATA_W,
    parameter int                  ADDR_W         = DEF_ADDR_W,
    parameter int                  BANKS          = DEF_BANKS,
    parameter logic [DATA_W-1:0]   CLEAR_VALUE    = '0,
    parameter bit                  CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    vram_banked_if.slave  bus,
    input  logic          clear_start,
    output logic          clear_busy
);
    localparam int BW    = clog2(BANKS);
    localparam int IDX_W = ADDR_W - BW;

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [BW-1:0]     bank_sel_q;
    logic              rdvalid_q;

    logic              clearing;
    logic              acc;
    logic [BW-1:0]     bank_idx;
    logic [IDX_W-1:0]  in_idx;
    logic [DATA_W-1:0] rdat [BANKS];

    assign clearing      = (state_q == ST_CLEAR);
    assign bus.bus_ready = (state_q == ST_IDLE) && !clear_start;
    assign acc           = bus.bus_valid && bus.bus_ready;
    assign bank_idx      = bus.bus_addr[ADDR_W-1 -: BW];
    assign in_idx        = bus.bus_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q      <= '0;
            bank_sel_q <= '0;
            rdvalid_q  <= 1'b0;
        end else begin
            rdvalid_q <= acc && !bus.bus_write;
            // Bank select follows the accepted read so the output mux stays aligned with it.
            if (acc && !bus.bus_write) bank_sel_q <= bank_idx;
            case (state_q)
                ST_IDLE: begin
                    if (clear_start) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        vram_bank #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (clearing || (acc && (bank_idx == BW'(b)))),
            .we_i   (clearing || bus.bus_write),
            .be_i   (clearing ? {(DATA_W/8){1'b1}} : bus.bus_wrbytesel),
            .idx_i  (clearing ? cnt_q : in_idx),
            .wdat_i (clearing ? CLEAR_VALUE : bus.bus_wrdata),
            .rdat_o (rdat[b])
        );
    end

    assign bus.bus_rddata  = rdat[bank_sel_q];
    assign bus.bus_rdvalid = rdvalid_q;
    assign clear_busy      = clearing;
endmodule

// File: tb/tb_vram_banked.sv
// Bench for vram_banked: vector table, corner sequences and randomized traffic against a memory model.
module tb_vram_banked;
    localparam int DEPTH = 16384;

    logic clk;
    logic rst_n;
    logic cs;
    logic busy;

    vram_banked_if #(.DATA_W(32), .ADDR_W(15)) bus_if ();

    vram_banked dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .clear_start (cs),
        .clear_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    logic [31:0] mem [int];
    int          clear_left;
    bit          pend;
    logic [31:0] last_rd;

    typedef struct {
        bit          v;
        bit          w;
        logic [14:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          exp_vld;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mread(input int a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic mwrite(input int a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = mread(a);
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        mem[a] = w;
    endtask

    // One bus cycle: entered just after a falling edge, returns at the next falling edge.
    task automatic step(input bit v, input bit w, input logic [14:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit c);
        bit er;
        bit acc;
        bus_if.bus_valid     = v;
        bus_if.bus_write     = w;
        bus_if.bus_addr      = a;
        bus_if.bus_wrdata    = d;
        bus_if.bus_wrbytesel = s;
        cs                   = c;
        #1;
        er = (clear_left == 0) && !c;
        check("ready", {31'b0, bus_if.bus_ready}, {31'b0, er});
        check("busy", {31'b0, busy}, {31'b0, clear_left > 0});
        acc = v && er;
        @(posedge clk);
        if (clear_left > 0) clear_left--;
        else if (c) begin
            clear_left = DEPTH;
            mem.delete();
        end
        pend = 1'b0;
        if (acc && w) mwrite(int'(a), d, s);
        if (acc && !w) begin
            pend    = 1'b1;
            last_rd = mread(int'(a));
        end
        @(negedge clk);
        check("rdvalid", {31'b0, bus_if.bus_rdvalid}, {31'b0, pend});
        check("rddata", bus_if.bus_rddata, last_rd);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 15'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic drain_clear();
        int guard;
        guard = 0;
        while (clear_left > 0 && guard < DEPTH + 8) begin
            idle();
            guard++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        pend    = 1'b0;
        last_rd = 32'h0;
        clear_left = 0;
        rst_n = 1'b0;
        cs    = 1'b0;
        bus_if.bus_valid     = 1'b0;
        bus_if.bus_write     = 1'b0;
        bus_if.bus_addr      = '0;
        bus_if.bus_wrdata    = '0;
        bus_if.bus_wrbytesel = '0;

        vecs[0]  = '{1, 1, 15'h4001, 32'h12345678, 4'hF, 0, 32'h0};
        vecs[1]  = '{1, 1, 15'h4001, 32'hAABBCCDD, 4'h5, 0, 32'h0};
        vecs[2]  = '{1, 0, 15'h4001, 32'h0,        4'h0, 1, 32'h12BB56DD};
        vecs[3]  = '{0, 0, 15'h0000, 32'h0,        4'h0, 0, 32'h12BB56DD};
        vecs[4]  = '{1, 1, 15'h0003, 32'h11111111, 4'hF, 0, 32'h12BB56DD};
        vecs[5]  = '{1, 1, 15'h4003, 32'h22222222, 4'hF, 0, 32'h12BB56DD};
        vecs[6]  = '{1, 0, 15'h0003, 32'h0,        4'h0, 1, 32'h11111111};
        vecs[7]  = '{1, 0, 15'h4003, 32'h0,        4'h0, 1, 32'h22222222};
        vecs[8]  = '{1, 0, 15'h0003, 32'h0,        4'h0, 1, 32'h11111111};
        vecs[9]  = '{1, 0, 15'h4003, 32'h0,        4'h0, 1, 32'h22222222};
        vecs[10] = '{1, 1, 15'h2222, 32'hCAFEF00D, 4'hF, 0, 32'h22222222};
        vecs[11] = '{1, 0, 15'h2222, 32'h0,        4'h0, 1, 32'hCAFEF00D};
        vecs[12] = '{0, 0, 15'h0000, 32'h0,        4'h0, 0, 32'hCAFEF00D};

        // Reset values with the automatic clear pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rddata", bus_if.bus_rddata, 32'h0);
        check("rst_rdvalid", {31'b0, bus_if.bus_rdvalid}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h1);
        check("rst_ready", {31'b0, bus_if.bus_ready}, 32'h0);

        rst_n = 1'b1;
        clear_left = DEPTH;
        drain_clear();
        step(1'b1, 1'b0, 15'h1000, 32'h0, 4'h0, 1'b0);
        check("read_after_clear", bus_if.bus_rddata, 32'h0);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, 1'b0);
            check($sformatf("vec%0d_vld", i), {31'b0, bus_if.bus_rdvalid}, {31'b0, vecs[i].exp_vld});
            check($sformatf("vec%0d_dat", i), bus_if.bus_rddata, vecs[i].exp_dat);
        end

        for (int i = 0; i < 400; i++) begin
            logic [14:0] a;
            a = 15'({$urandom_range(0, 1), 11'h020, 3'($urandom_range(0, 7))});
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                 $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end

        // Clear request beats a simultaneous write; a second request mid-clear is ignored.
        step(1'b1, 1'b1, 15'h0010, 32'hDEADBEEF, 4'hF, 1'b1);
        repeat (50) idle();
        step(1'b0, 1'b0, 15'h0, 32'h0, 4'h0, 1'b1);
        drain_clear();
        step(1'b1, 1'b0, 15'h0010, 32'h0, 4'h0, 1'b0);
        check("cleared_0010", bus_if.bus_rddata, 32'h0);

        // Reset in the middle of a clear.
        step(1'b1, 1'b1, 15'h0005, 32'h5A5A5A5A, 4'hF, 1'b0);
        step(1'b1, 1'b0, 15'h0005, 32'h0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 15'h0, 32'h0, 4'h0, 1'b1);
        repeat (100) idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rddata", bus_if.bus_rddata, 32'h0);
        check("midrst_rdvalid", {31'b0, bus_if.bus_rdvalid}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h1);
        check("midrst_ready", {31'b0, bus_if.bus_ready}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_left = DEPTH;
        pend = 1'b0;
        last_rd = 32'h0;
        mem.delete();
        drain_clear();
        step(1'b1, 1'b0, 15'h0005, 32'h0, 4'h0, 1'b0);
        check("after_rst_0005", bus_if.bus_rddata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vram_banked.md
VRAM_BANKED -- requirements
Module: vram_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 15, meaning word-address width.
REQ-003 SHALL have parameter BANKS, default 2, meaning bank count, a power of 2, at least 2.
REQ-004 SHALL have parameter CLEAR_VALUE, default 0, meaning the word written by the clear engine.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, meaning that a clear starts automatically on reset release.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 bus_addr  in  ADDR_W  word address.
REQ-009 bus_wrdata  in  DATA_W  write data.
REQ-010 bus_wrbytesel  in  DATA_W/8  per-byte write enables.
REQ-011 bus_write  in  1  1 = write, 0 = read.
REQ-012 bus_valid  in  1  request present.
REQ-013 bus_ready  out  1  request accepted when bus_valid&&bus_ready.
REQ-014 bus_rddata  out  DATA_W  registered read data.
REQ-015 bus_rdvalid  out  1  one-cycle pulse, bus_rddata valid.
REQ-016 clear_start  in  1  pulse requesting a full clear.
REQ-017 clear_busy  out  1  clear in progress.

Function
REQ-018 Bank index SHALL be bus_addr[ADDR_W-1 -: log2(BANKS)]; in-bank index SHALL be the remaining low bits; each bank holds 2^(ADDR_W-log2(BANKS)) words.
REQ-019 FSM SHALL have two states: IDLE and CLEAR.
REQ-020 IDLE to CLEAR SHALL occur on clear_start; CLEAR to IDLE SHALL occur on the cycle the counter writes the last index.
REQ-021 bus_ready SHALL be combinational: (state==IDLE) && !clear_start.
REQ-022 clear_start SHALL win over a simultaneous bus_valid; the request is not accepted.
REQ-023 An accepted write SHALL update only the selected bank, and only the bytes with bus_wrbytesel bit set.
REQ-024 An accepted read SHALL give bus_rdvalid=1 and bus_rddata=word exactly 1 cycle after acceptance.
REQ-025 Back-to-back reads at one per cycle SHALL be supported with no bubbles, including alternating banks.
REQ-026 The read bank select SHALL be registered alongside the read, so the output mux uses the bank of the accepted request.
REQ-027 bus_rddata SHALL hold its last value while no read is returned.
REQ-028 A write followed by a read of the same address on the next cycle SHALL return the new data.
REQ-029 In CLEAR, each cycle SHALL write CLEAR_VALUE, with all bytes enabled, to index cnt in all banks in parallel.
REQ-030 The clear counter SHALL be an index-width counter from 0 to the last index, so a clear takes 2^(ADDR_W-log2(BANKS)) cycles.
REQ-031 clear_start while in CLEAR SHALL be ignored; the counter does not restart.
REQ-032 clear_busy SHALL be 1 exactly while state==CLEAR.
REQ-033 No read SHALL be issued during CLEAR.

Reset
REQ-034 On rst_n low, asynchronously: bus_rddata=0, bus_rdvalid=0, counter=0, registered bank select=0.
REQ-035 On rst_n low, the state SHALL be CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-036 Hence on rst_n low bus_ready=0 and clear_busy=1 when CLEAR_ON_RESET=1, and bus_ready=1 (absent clear_start) and clear_busy=0 when CLEAR_ON_RESET=0.
REQ-037 Memory contents SHALL NOT be reset, and are cleared only by the clear engine.
REQ-038 Reset asserted mid-clear SHALL abort the clear; with CLEAR_ON_RESET=1 the clear restarts from index 0.

Structure
REQ-039 Package vram_pkg SHALL hold the state enum, a clog2 function and default parameter constants.
REQ-040 Sub-module vram_bank SHALL be a single-port synchronous RAM with byte write enables and a 1-cycle registered read, instantiated BANKS times via generate.

Verification (DATA_W=32, ADDR_W=15, BANKS=2, CLEAR_VALUE=0)
REQ-041 Release rst_n -> clear_busy=1, bus_ready=0 for 16384 cycles, then IDLE; read 0x1000 -> 0x00000000.
REQ-042 Write 0x12345678 with sel=0xF at 0x4001, then write 0xAABBCCDD with sel=0x5 at 0x4001, then read -> 0x12BB56DD, with rdvalid exactly 1 cycle after acceptance.
REQ-043 Write 0x11111111 at 0x0003 and 0x22222222 at 0x4003; read alternately every cycle x4 -> 0x11111111, 0x22222222, 0x11111111, 0x22222222 on consecutive cycles.
REQ-044 clear_start together with a bus_valid write of 0xDEADBEEF at 0x0010 -> write not accepted; after the clear, a read of 0x0010 -> 0x00000000.
REQ-045 Assert rst_n at clear count 100 -> outputs take their reset values at once; after release, clear_busy lasts a full 16384 cycles from index 0.
REQ-046 Write at 0x2222, then read at 0x2222 on the next cycle -> the new data.
